pip_reg_stage: RTL and testbench

PIP_REG_STAGE -- requirements
Module: pip_reg_stage

---
 rtl/pip_reg_stage.sv | 108 ++++++++++
 tb/tb_pip_reg_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pip_reg_stage.sv
// pip_reg_stage: valid/ready pipeline register with optional two-entry skid buffer, flush and stall counter.
module pip_reg_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 12,
  parameter int SKID_EN    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic                  ready_q, ready_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  in_beat, out_beat;

  assign valid_o     = state_q != EMPTY;
  // skid mode breaks the ready_i -> ready_o path by registering ready
  assign ready_o     = (SKID_EN != 0) ? ready_q : (!valid_o || ready_i);
  assign data_o      = main_data_q;
  assign ctrl_o      = valid_o ? main_ctrl_q : '0;
  assign stall_cnt_o = cnt_q;
  assign in_beat     = valid_i && ready_o && !flush_i;
  assign out_beat    = valid_o && ready_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else if (SKID_EN == 0) begin
      if (in_beat) begin
        state_d     = ONE;
        main_data_d = data_i;
        main_ctrl_d = ctrl_i;
      end else if (out_beat) begin
        state_d = EMPTY;
      end
    end else begin
      case (state_q)
        EMPTY: if (in_beat) begin
          state_d     = ONE;
          main_data_d = data_i;
          main_ctrl_d = ctrl_i;
        end
        ONE: if (in_beat && out_beat) begin
          main_data_d = data_i;
          main_ctrl_d = ctrl_i;
        end else if (in_beat) begin
          state_d     = TWO;
          skid_data_d = data_i;
          skid_ctrl_d = ctrl_i;
        end else if (out_beat) begin
          state_d = EMPTY;
        end
        TWO: if (out_beat) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = state_d != TWO;
    cnt_d   = (!flush_i && valid_o && !ready_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pip_reg_stage.sv
// tb_pip_reg_stage: directed checks of skid, single-register and saturating-counter variants.
module tb_pip_reg_stage;
  logic        clk = 0, rst_n = 0, flush = 0, valid_i = 0, ready_i = 0;
  logic [31:0] data_i = 0;
  logic [11:0] ctrl_i = 0;
  logic        a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
  logic [31:0] a_data, b_data, c_data;
  logic [11:0] a_ctrl, b_ctrl, c_ctrl;
  logic [15:0] a_cnt, c_cnt;
  logic [3:0]  b_cnt;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pip_reg_stage dut_a (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(a_ready),
    .data_i(data_i), .ctrl_i(ctrl_i), .valid_o(a_valid), .ready_i(ready_i), .data_o(a_data), .ctrl_o(a_ctrl),
    .stall_cnt_o(a_cnt));
  pip_reg_stage #(.CNT_WIDTH(4)) dut_b (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i),
    .ready_o(b_ready), .data_i(data_i), .ctrl_i(ctrl_i), .valid_o(b_valid), .ready_i(ready_i), .data_o(b_data),
    .ctrl_o(b_ctrl), .stall_cnt_o(b_cnt));
  pip_reg_stage #(.SKID_EN(0)) dut_c (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i),
    .ready_o(c_ready), .data_i(data_i), .ctrl_i(ctrl_i), .valid_o(c_valid), .ready_i(ready_i), .data_o(c_data),
    .ctrl_o(c_ctrl), .stall_cnt_o(c_cnt));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; flush = 0; valid_i = 0; ready_i = 0; data_i = 0; ctrl_i = 0;
    step;
    rst_n = 1;
  endtask

  task automatic test_reset;
    do_reset;
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", a_valid); end
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", a_ready); end
    n_vec++; if (a_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", a_data); end
    n_vec++; if (a_ctrl !== 12'h0) begin n_err++; $display("FAIL reset_ctrl got %h exp 0", a_ctrl); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", a_cnt); end
    n_vec++; if (c_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_noskid got %b exp 1", c_ready); end
  endtask

  task automatic test_stream;
    do_reset;
    valid_i = 1; ready_i = 1;
    for (int i = 1; i <= 5; i++) begin
      data_i = 32'(i); ctrl_i = 12'(i * 3);
      step;
      n_vec++; if (a_valid !== 1'b1 || a_data !== 32'(i)) begin n_err++; $display("FAIL stream_data%0d got %b/%h exp 1/%h", i, a_valid, a_data, i); end
      n_vec++; if (a_ctrl !== 12'(i * 3)) begin n_err++; $display("FAIL stream_ctrl%0d got %h exp %h", i, a_ctrl, i * 3); end
      n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready%0d got %b exp 1", i, a_ready); end
    end
    valid_i = 0;
    step;
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid got %b exp 0", a_valid); end
    n_vec++; if (a_ctrl !== 12'h0) begin n_err++; $display("FAIL bubble_ctrl got %h exp 0", a_ctrl); end
    n_vec++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL stream_cnt got %0d exp 0", a_cnt); end
  endtask

  task automatic test_skid_fill;
    do_reset;
    valid_i = 1; ready_i = 0; data_i = 32'hA; ctrl_i = 12'h00A;
    step;
    data_i = 32'hB; ctrl_i = 12'h00B;
    step;
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_two got %b exp 0", a_ready); end
    n_vec++; if (a_data !== 32'hA) begin n_err++; $display("FAIL skid_hold_a got %h exp a", a_data); end
    valid_i = 0;
    step;
    n_vec++; if (a_data !== 32'hA || a_ready !== 1'b0) begin n_err++; $display("FAIL skid_stall got %h/%b exp a/0", a_data, a_ready); end
    ready_i = 1;
    step;
    n_vec++; if (a_valid !== 1'b1 || a_data !== 32'hB || a_ctrl !== 12'h00B) begin n_err++; $display("FAIL skid_out_b got %b/%h/%h exp 1/b/00b", a_valid, a_data, a_ctrl); end
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_one got %b exp 1", a_ready); end
    step;
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL skid_drain got %b exp 0", a_valid); end
    n_vec++; if (a_cnt !== 16'd2) begin n_err++; $display("FAIL skid_cnt got %0d exp 2", a_cnt); end
  endtask

  task automatic test_flush_two;
    do_reset;
    valid_i = 1; ready_i = 0; data_i = 32'hA;
    step;
    data_i = 32'hB;
    step;
    flush = 1; data_i = 32'hC; ctrl_i = 12'hFFF;
    step;
    n_vec++; if (a_valid !== 1'b0 || a_ctrl !== 12'h0) begin n_err++; $display("FAIL flush_valid_ctrl got %b/%h exp 0/0", a_valid, a_ctrl); end
    n_vec++; if (a_ready !== 1'b1 || a_data !== 32'h0) begin n_err++; $display("FAIL flush_ready_data got %b/%h exp 1/0", a_ready, a_data); end
    n_vec++; if (a_cnt !== 16'd1) begin n_err++; $display("FAIL flush_cnt got %0d exp 1", a_cnt); end
    flush = 0; valid_i = 0; ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      n_vec++; if (a_valid !== 1'b0 || a_data !== 32'h0) begin n_err++; $display("FAIL flush_leak%0d got %b/%h exp 0/0", i, a_valid, a_data); end
    end
  endtask

  task automatic test_saturation;
    do_reset;
    valid_i = 1; ready_i = 0; data_i = 32'h5;
    step;
    valid_i = 0;
    for (int k = 1; k <= 20; k++) begin
      step;
      if (k == 10) begin
        n_vec++; if (b_cnt !== 4'd10) begin n_err++; $display("FAIL sat_mid got %0d exp 10", b_cnt); end
      end
    end
    n_vec++; if (b_cnt !== 4'd15) begin n_err++; $display("FAIL sat_20 got %0d exp 15", b_cnt); end
    step; step;
    n_vec++; if (b_cnt !== 4'd15 || b_valid !== 1'b1) begin n_err++; $display("FAIL sat_hold got %0d/%b exp 15/1", b_cnt, b_valid); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    valid_i = 1; ready_i = 0; data_i = 32'hA;
    step;
    data_i = 32'hB;
    step;
    valid_i = 0;
    repeat (4) step;
    n_vec++; if (a_cnt !== 16'd5 || a_ready !== 1'b0) begin n_err++; $display("FAIL pre_rst got %0d/%b exp 5/0", a_cnt, a_ready); end
    rst_n = 0; flush = 1; valid_i = 1; ready_i = 1;
    step;
    rst_n = 1; flush = 0; valid_i = 0; ready_i = 0;
    n_vec++; if (a_valid !== 1'b0 || a_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_vr got %b/%b exp 0/1", a_valid, a_ready); end
    n_vec++; if (a_cnt !== 16'd0 || a_data !== 32'h0) begin n_err++; $display("FAIL mid_rst_cd got %0d/%h exp 0/0", a_cnt, a_data); end
  endtask

  task automatic test_noskid;
    do_reset;
    valid_i = 1; ready_i = 0; data_i = 32'h11; ctrl_i = 12'h011;
    step;
    data_i = 32'h22;
    #1;
    n_vec++; if (c_valid !== 1'b1 || c_ready !== 1'b0) begin n_err++; $display("FAIL noskid_stall got %b/%b exp 1/0", c_valid, c_ready); end
    step;
    n_vec++; if (c_data !== 32'h11) begin n_err++; $display("FAIL noskid_hold got %h exp 11", c_data); end
    ready_i = 1; data_i = 32'h33; ctrl_i = 12'h033;
    #1;
    n_vec++; if (c_ready !== 1'b1) begin n_err++; $display("FAIL noskid_comb_ready got %b exp 1", c_ready); end
    step;
    n_vec++; if (c_valid !== 1'b1 || c_data !== 32'h33 || c_ctrl !== 12'h033) begin n_err++; $display("FAIL noskid_load got %b/%h/%h exp 1/33/033", c_valid, c_data, c_ctrl); end
    valid_i = 0;
    step;
    n_vec++; if (c_valid !== 1'b0 || c_ctrl !== 12'h0) begin n_err++; $display("FAIL noskid_drain got %b/%h exp 0/0", c_valid, c_ctrl); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_skid_fill;
    test_flush_two;
    test_saturation;
    test_reset_mid;
    test_noskid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
